// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment MMIO responder.
//   - register word offsets
//   - CTRL field positions and writable mask
//   - seven-segment patterns (active-high, bit0 = segment a)
//   - byte-lane merge helper for partial stores
package seg7_pkg;

  localparam int unsigned SEG7_DATA   = 0;
  localparam int unsigned SEG7_CTRL   = 1;
  localparam int unsigned SEG7_STATUS = 2;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_BLANK_LSB  = 4;
  localparam int unsigned CTRL_BRIGHT_LSB = 8;

  // Pin-level idle levels (active-low board pins).
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_BLANK  = 4'hF;

  // Hex glyphs, entry n is the active-high pattern for nibble n.
  localparam logic [15:0][6:0] SEG7_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic        sel;
    logic        rd;
    logic [3:0]  we;
    logic [31:0] wdata;
  } seg7_req_t;

  // Replace the byte lanes of old_v selected by we with those of new_v.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  we);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (we[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/seg7_mmio_responder_hex.sv
// hex_to_seg7: combinational nibble to seven-segment pattern.
//   nib_i [3:0]  hex digit
//   seg_o [6:0]  segments a..g, active-high, bit0 = a
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG7_HEX[nib_i];
endmodule

// File: rtl/seg7_mmio_responder.sv
// seg7_mmio_responder: memory-mapped 4-digit seven-segment display driver.
//   Word map: 0 DATA[15:0], 1 CTRL {bright[11:8], blank[7:4], en[0]},
//             2 STATUS {frame[15:8], idx[1:0]} (read-only), 3 reserved.
// Ports:
//   clk_i, rst_i (async, active-high)
//   sel_i        window select; rd_i/we_i ignored when low
//   rd_i         load strobe, data_out_o valid one cycle later
//   we_i[3:0]    byte write enables
//   addr_i       word offset
//   data_in_i    store data
//   data_out_o   registered load data, holds between loads
//   seg_o[6:0]   segments a..g, active-low
//   an_o[3:0]    digit anodes, active-low, bit0 = rightmost
// Build option: define SEG7_BRIGHTNESS_EN to enable the CTRL[11:8] duty
// control (CTRL then resets to 0x0000_0F00).
module seg7_mmio_responder
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned ADDR_W      = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sel_i,
  input  logic              rd_i,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_in_i,
  output logic [31:0]       data_out_o,
  output logic [6:0]        seg_o,
  output logic [3:0]        an_o
);
  localparam int unsigned     DIV_W    = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  seg7_req_t req;
  assign req = '{sel: sel_i, rd: rd_i, we: we_i, wdata: data_in_i};

  logic [15:0]      data_q, data_d;
  logic             en_q, en_d;
  logic [3:0]       blank_q, blank_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       frame_q, frame_d;
  logic [31:0]      dout_q, dout_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             duty_on;

`ifdef SEG7_BRIGHTNESS_EN
  logic [3:0] bright_q, bright_d;
  // Lit while the divider is inside the first d sixteenths of the slot.
  localparam int unsigned SLOT_STEP = REFRESH_DIV / 16;
  logic [31:0] duty_lim;
  assign duty_lim = 32'(SLOT_STEP) * {28'h0, bright_q};
  assign duty_on  = 32'(div_q) < duty_lim;
`else
  logic [3:0] bright_q;
  assign bright_q = 4'h0;
  assign duty_on  = 1'b1;
`endif

  // Address decode
  logic hit_data, hit_ctrl, hit_stat, wr_en, rd_en;
  assign hit_data = (addr_i == ADDR_W'(SEG7_DATA));
  assign hit_ctrl = (addr_i == ADDR_W'(SEG7_CTRL));
  assign hit_stat = (addr_i == ADDR_W'(SEG7_STATUS));
  assign wr_en    = req.sel && (req.we != 4'b0);
  assign rd_en    = req.sel && req.rd;

  // Readback views and byte-merged store values
  logic [31:0] data_rd, ctrl_rd, stat_rd, data_wr, ctrl_wr;
  assign data_rd = {16'h0, data_q};
  assign ctrl_rd = {20'h0, bright_q, blank_q, 3'b000, en_q};
  assign stat_rd = {16'h0, frame_q, 6'h0, idx_q};
  assign data_wr = byte_merge(data_rd, req.wdata, req.we);
  assign ctrl_wr = byte_merge(ctrl_rd, req.wdata, req.we);

  // Merged bits that map to no storage
  logic unused_bits;
  assign unused_bits = ^{data_wr[31:16], ctrl_wr[31:12], ctrl_wr[11:8], ctrl_wr[3:1]};

  // Register writes and load data. Reads sample the _q values, so a
  // simultaneous rd+we returns the pre-write contents.
  always_comb begin
    data_d  = data_q;
    en_d    = en_q;
    blank_d = blank_q;
`ifdef SEG7_BRIGHTNESS_EN
    bright_d = bright_q;
`endif
    dout_d  = dout_q;
    if (wr_en && hit_data) data_d = data_wr[15:0];
    if (wr_en && hit_ctrl) begin
      en_d    = ctrl_wr[CTRL_EN_BIT];
      blank_d = ctrl_wr[CTRL_BLANK_LSB +: 4];
`ifdef SEG7_BRIGHTNESS_EN
      bright_d = ctrl_wr[CTRL_BRIGHT_LSB +: 4];
`endif
    end
    if (rd_en) begin
      if (hit_data)      dout_d = data_rd;
      else if (hit_ctrl) dout_d = ctrl_rd;
      else if (hit_stat) dout_d = stat_rd;
      else               dout_d = 32'h0;
    end
  end

  // Scan: free-running regardless of enable
  logic div_last;
  assign div_last = (div_q == DIV_LAST);
  always_comb begin
    div_d   = div_last ? '0 : div_q + 1'b1;
    idx_d   = div_last ? idx_q + 2'd1 : idx_q;
    frame_d = (div_last && idx_q == 2'd3) ? frame_q + 8'd1 : frame_q;
  end

  // Digit select and glyph
  logic [3:0][3:0] nib;
  logic [6:0]      pat;
  logic            lit;
  assign nib = data_q;

  hex_to_seg7 u_hex (
    .nib_i (nib[idx_q]),
    .seg_o (pat)
  );

  assign lit = en_q && !blank_q[idx_q] && duty_on;

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = AN_BLANK;
    if (lit) begin
      seg_d = ~pat;
      an_d  = ~(4'b0001 << idx_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      en_q    <= 1'b0;
      blank_q <= '0;
`ifdef SEG7_BRIGHTNESS_EN
      bright_q <= 4'hF;
`endif
      div_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      dout_q  <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= AN_BLANK;
    end else begin
      data_q  <= data_d;
      en_q    <= en_d;
      blank_q <= blank_d;
`ifdef SEG7_BRIGHTNESS_EN
      bright_q <= bright_d;
`endif
      div_q   <= div_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      dout_q  <= dout_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign data_out_o = dout_q;
  assign seg_o      = seg_q;
  assign an_o       = an_q;

endmodule

// File: tb/tb_seg7_mmio_responder.sv
// Bench for seg7_mmio_responder: cycle reference model plus a read
// scoreboard; display pins and data_out are compared every cycle.
module tb_seg7_mmio_responder;
`ifdef SEG7_BRIGHTNESS_EN
  localparam int RDIV = 32;
  localparam logic [31:0] CMASK = 32'h0000_0FF1;
  localparam logic [31:0] CRST  = 32'h0000_0F00;
`else
  localparam int RDIV = 4;
  localparam logic [31:0] CMASK = 32'h0000_00F1;
  localparam logic [31:0] CRST  = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst, sel, rd;
  logic [3:0]  we;
  logic [1:0]  addr;
  logic [31:0] din, dout;
  logic [6:0]  seg;
  logic [3:0]  an;

  always #5 clk = ~clk;

  seg7_mmio_responder #(.REFRESH_DIV(RDIV), .ADDR_W(2)) dut (
    .clk_i(clk), .rst_i(rst), .sel_i(sel), .rd_i(rd), .we_i(we),
    .addr_i(addr), .data_in_i(din), .data_out_o(dout), .seg_o(seg), .an_o(an)
  );

  // Active-low glyphs for 0..F
  localparam logic [6:0] SEG_AL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int n_vec = 0, n_bad = 0;
  logic [31:0] exp_q[$];

  // Reference state
  logic [31:0] m_data, m_ctrl, m_dout;
  logic [1:0]  m_idx;
  logic [7:0]  m_frame;
  int          m_div, m_frames_total;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_data = 0; m_ctrl = CRST; m_dout = 0; m_idx = 0; m_frame = 0;
    m_div = 0; m_frames_total = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_data;
      2'd1:    return m_ctrl;
      2'd2:    return {16'h0, m_frame, 6'h0, m_idx};
      default: return 32'h0;
    endcase
  endfunction

  // {an, seg} expected one cycle after the current model state
  function automatic logic [10:0] m_disp();
    logic [3:0] a;
    logic [3:0] n;
    bit lit;
    lit = m_ctrl[0] && !m_ctrl[4 + m_idx];
`ifdef SEG7_BRIGHTNESS_EN
    lit = lit && (m_div < (RDIV / 16) * int'(m_ctrl[11:8]));
`endif
    if (!lit) return {4'hF, 7'h7F};
    a = 4'b0001 << m_idx;
    n = m_data[4*m_idx +: 4];
    return {~a, SEG_AL[n]};
  endfunction

  task automatic tick();
    logic [10:0] d;
    logic [31:0] wm, e;
    bit rd_now;
    d = m_disp();
    rd_now = sel && rd;
    if (rd_now) exp_q.push_back(m_read(addr));
    if (sel && we != 4'b0) begin
      wm = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
      if (addr == 2'd0) m_data = ((m_data & ~wm) | (din & wm)) & 32'h0000_FFFF;
      if (addr == 2'd1) m_ctrl = ((m_ctrl & ~wm) | (din & wm)) & CMASK;
    end
    if (m_div == RDIV - 1) begin
      m_div = 0;
      if (m_idx == 2'd3) begin m_frame++; m_frames_total++; end
      m_idx++;
    end else m_div++;
    @(posedge clk); #1;
    chk("an", {28'h0, an}, {28'h0, d[10:7]});
    chk("seg", {25'h0, seg}, {25'h0, d[6:0]});
    if (rd_now) begin
      e = exp_q.pop_front();
      m_dout = e;
      chk("rdata", dout, e);
    end else chk("dout_hold", dout, m_dout);
  endtask

  task automatic bus(input logic s, input logic r, input logic [3:0] w,
                     input logic [1:0] a, input logic [31:0] dv);
    sel = s; rd = r; we = w; addr = a; din = dv;
    tick();
    sel = 0; rd = 0; we = 0; din = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  int cnt;

  initial begin
    rst = 1; sel = 0; rd = 0; we = 0; addr = 0; din = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", {28'h0, an}, 32'hF);
    chk("rst_seg", {25'h0, seg}, 32'h7F);
    chk("rst_dout", dout, 32'h0);
    rst = 0;

    // Dark after reset, scan still running
    idle(10);
    repeat (6) begin bus(1, 1, 0, 2, 0); idle(RDIV / 2); end

    // Basic display
    bus(1, 0, 4'hF, 0, 32'h0000_1234);
    bus(1, 0, 4'hF, 1, 32'h0000_0001 | CRST);
    idle(4 * RDIV + 2);

    // Byte-enable store
    bus(1, 0, 4'b0001, 0, 32'hFFFF_FFAB);
    bus(1, 1, 0, 0, 0);
    chk("byte_we", dout, 32'h0000_12AB);

    // Blank digit 1
    bus(1, 0, 4'hF, 1, 32'h0000_0021 | CRST);
    idle(4 * RDIV + 2);

    // Read during write returns old value
    bus(1, 0, 4'hF, 0, 32'h5);
    bus(1, 1, 4'hF, 0, 32'h9);
    chk("rdwr_old", dout, 32'h5);
    bus(1, 1, 0, 0, 0);
    chk("rdwr_new", dout, 32'h9);
    bus(0, 1, 4'hF, 0, 32'h7);
    bus(1, 1, 0, 0, 0);
    chk("sel0_ignored", dout, 32'h9);

    // Mask, read-only and reserved
    bus(1, 0, 4'hF, 2, 32'hFFFF_FFFF);
    bus(1, 0, 4'hF, 3, 32'hFFFF_FFFF);
    bus(1, 1, 0, 3, 0);
    bus(1, 0, 4'hF, 1, 32'hFFFF_FFFF);
    bus(1, 1, 0, 1, 0);
    chk("ctrl_mask", dout, CMASK);
    bus(1, 0, 4'b0011, 0, 32'hFFFF_BEEF);
    bus(1, 1, 0, 0, 0);
    bus(1, 0, 4'hF, 1, 32'h0000_0001 | CRST);
    idle(4 * RDIV);

`ifdef SEG7_BRIGHTNESS_EN
    bus(1, 0, 4'hF, 1, 32'h0000_0801);
    idle(RDIV + 1);
    cnt = 0;
    repeat (RDIV) begin tick(); if (an != 4'hF) cnt++; end
    chk("duty_half", cnt, RDIV / 2);
`endif

    // Run to 300 frames, then reset mid-slot
    while (m_frames_total < 300) tick();
    idle(2);
    bus(1, 1, 0, 2, 0);
    chk("frame_wrap", {24'h0, dout[15:8]}, 32'd44);
    #2 rst = 1;
    #1;
    chk("async_an", {28'h0, an}, 32'hF);
    chk("async_seg", {25'h0, seg}, 32'h7F);
    chk("async_dout", dout, 32'h0);
    m_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    bus(1, 1, 0, 2, 0);
    chk("post_rst_stat", dout, 32'h0);
    idle(RDIV + 3);
    bus(1, 1, 0, 1, 0);
    chk("post_rst_ctrl", dout, CRST);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
